// File: rtl/square_iter_if.sv
// Handshake bundle for the iterative squarer: go/root request side,
// sq/busy/done completion side.
interface square_iter_if #(
  parameter int WIDTH = 8
);
  logic               go;
  logic [WIDTH-1:0]   root;
  logic [2*WIDTH-1:0] sq;
  logic               busy;
  logic               done;

  modport master (output go, root, input sq, busy, done);
  modport slave  (input go, root, output sq, busy, done);
endinterface

// File: rtl/square_iter.sv
// Iterative shift-add squarer: sq = root*root, one multiplier bit per clock,
// WIDTH cycles per operation, go/done handshake shared with the sqrt unit.
module square_iter #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  square_iter_if.slave bus
);

  localparam int SQ_W  = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t            state, state_nxt;
  logic [SQ_W-1:0]   acc, acc_sum;
  logic [SQ_W-1:0]   mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CNT_W-1:0]  cnt;
  logic [SQ_W-1:0]   sq_q;
  logic              done_q;
  logic              accept;
  logic              last_bit;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_bit  = 1'b0;
    acc_sum   = acc + (mplier[0] ? mcand : '0);
    case (state)
      IDLE: begin
        if (bus.go) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_bit  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured on the accepting edge, so root/go activity during
  // CALC cannot disturb the running product.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      sq_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, bus.root};
        mplier <= bus.root;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last_bit) begin
          sq_q   <= acc_sum;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.sq   = sq_q;
  assign bus.busy = (state == CALC);
  assign bus.done = done_q;

endmodule

// File: tb/tb_square_iter.sv
// Scoreboard bench for square_iter: the driver queues the expected square at
// each accepted request, a negedge monitor pops and compares on every done.
module tb_square_iter;

  localparam int WIDTH = 8;

  typedef struct {
    int unsigned root;
    int unsigned sq;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  square_iter_if #(.WIDTH(WIDTH)) bus ();

  square_iter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   done_count = 0;
  logic prev_done  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned isqrt(input int unsigned v);
    int unsigned r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      done_count++;
      check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got sq=%0d, expected no completion", bus.sq);
      end else begin
        e = sb_q.pop_front();
        check("sq", {16'd0, bus.sq}, e.sq);
        check("loopback_isqrt", isqrt({16'd0, bus.sq}), e.root);
      end
    end
    prev_done = bus.done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sq(input int unsigned r, input int unsigned s);
    exp_t e;
    e.root = r;
    e.sq   = s;
    sb_q.push_back(e);
  endtask

  // Issue one request and follow it to done; reports latency and busy cycles.
  task automatic run_one(input int unsigned r, input int unsigned s,
                         output int lat, output int busy_cycles);
    bus.go   = 1'b1;
    bus.root = WIDTH'(r);
    @(posedge clk);
    expect_sq(r, s);
    #1;
    bus.go      = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.busy) busy_cycles++;
      tick();
      lat++;
      if (bus.done) break;
    end
  endtask

  task automatic wait_idle_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int lat, busy_cycles, d0, t_first;
  int unsigned vec_root[4] = '{0, 255, 170, 1};
  int unsigned vec_sq[4]   = '{0, 65025, 28900, 1};

  initial begin
    bus.go   = 1'b0;
    bus.root = '0;

    // Reset for 5 clocks, then the idle state must be clean.
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_sq", {16'd0, bus.sq}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);

    // Directed edge values: latency and busy window for each.
    for (int i = 0; i < 4; i++) begin
      run_one(vec_root[i], vec_sq[i], lat, busy_cycles);
      check("latency", lat, WIDTH);
      check("busy_cycles", busy_cycles, WIDTH);
      check("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
      wait_idle_cycles(2);
    end

    // Sweep every root, one request per done.
    d0 = done_count;
    for (int r = 1; r < 256; r++) begin
      run_one(r, r * r, lat, busy_cycles);
      check("sweep_latency", lat, WIDTH);
    end
    tick();
    check("sweep_done_count", done_count - d0, 255);

    // go held high: re-squares every WIDTH+1 cycles; root switched in the done cycle.
    bus.go   = 1'b1;
    bus.root = 8'd12;
    @(posedge clk);
    expect_sq(12, 144);
    #1;
    lat = 0;
    for (int k = 0; k < 40 && !bus.done; k++) begin tick(); lat++; end
    check("held_first_latency", lat, WIDTH);
    bus.root = 8'd13;
    @(posedge clk);
    expect_sq(13, 169);
    #1;
    t_first = 1;
    for (int k = 0; k < 40 && !bus.done; k++) begin tick(); t_first++; end
    bus.go = 1'b0;
    check("held_done_interval", t_first, WIDTH + 1);
    wait_idle_cycles(12);

    // go re-asserted and root changed mid-CALC are ignored.
    d0 = done_count;
    bus.go   = 1'b1;
    bus.root = 8'd77;
    @(posedge clk);
    expect_sq(77, 5929);
    #1;
    bus.go = 1'b0;
    tick();
    tick();
    bus.go   = 1'b1;
    bus.root = 8'd99;
    tick();
    tick();
    bus.go   = 1'b0;
    bus.root = 8'd5;
    wait_idle_cycles(20);
    check("midcalc_single_done", done_count - d0, 1);

    // Reset in the 4th CALC cycle aborts with no done and clears sq.
    d0 = done_count;
    bus.go   = 1'b1;
    bus.root = 8'd200;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy_before_rst", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_sq", {16'd0, bus.sq}, 32'd0);
    wait_idle_cycles(12);
    check("abort_no_done", done_count - d0, 0);

    // rst and go together: rst wins, nothing starts.
    rst      = 1'b1;
    bus.go   = 1'b1;
    bus.root = 8'd50;
    tick();
    rst    = 1'b0;
    bus.go = 1'b0;
    check("rst_go_busy", {31'd0, bus.busy}, 32'd0);
    wait_idle_cycles(12);
    check("rst_go_no_done", done_count - d0, 0);

    run_one(3, 9, lat, busy_cycles);
    check("after_abort_latency", lat, WIDTH);
    wait_idle_cycles(4);
    check("sq_holds", {16'd0, bus.sq}, 32'd9);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
